// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area geometry, RGB565 field layout and
// the line-fetch FSM state encoding used by the pixel-fetch path.
package vga_pkg;

   localparam int unsigned H_ACTIVE  = 640;
   localparam int unsigned V_ACTIVE  = 480;
   localparam int unsigned COORD_W   = 11;
   localparam int unsigned FB_ADDR_W = 17;
   localparam int unsigned PIX_W     = 16;
   localparam int unsigned COLOR_W   = 10;

   localparam int unsigned R_MSB = 15;
   localparam int unsigned R_LSB = 11;
   localparam int unsigned G_MSB = 10;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_MSB = 4;
   localparam int unsigned B_LSB = 0;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_ISSUE = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [COLOR_W-1:0] red;
      logic [COLOR_W-1:0] green;
      logic [COLOR_W-1:0] blue;
   } rgb30_t;

   // Widen each RGB565 field to 10 bits by repeating its MSBs into the LSBs.
   function automatic rgb30_t expandRgb565(input logic [PIX_W-1:0] pix);
      rgb30_t c;
      c.red   = {pix[R_MSB:R_LSB], pix[R_MSB:R_LSB]};
      c.green = {pix[G_MSB:G_LSB], pix[G_MSB:G_MSB-3]};
      c.blue  = {pix[B_MSB:B_LSB], pix[B_MSB:B_LSB]};
      return c;
   endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Two-bank line buffer: simple dual-port RAM, one write port for the fetch
// engine and one registered read port for the display side.
module vga_line_ram
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 320,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic               iCLK,
   input  logic               iWrEn,
   input  logic               iWrBank,
   input  logic [IDX_W-1:0]   iWrIdx,
   input  logic [PIX_W-1:0]   iWrData,
   input  logic               iRdBank,
   input  logic [IDX_W-1:0]   iRdIdx,
   output logic [PIX_W-1:0]   oRdData
);

   logic [PIX_W-1:0] mem [2][DEPTH];

   // Storage is intentionally not reset; only the ready bits qualify it.
   always_ff @(posedge iCLK) begin
      if (iWrEn) begin
         mem[iWrBank][iWrIdx] <= iWrData;
      end
      oRdData <= mem[iRdBank][iRdIdx];
   end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches source lines from the frame buffer into a ping-pong line buffer and
// serves 2x-upscaled RGB565 pixels to the VGA timing generator.
module vga_pixel_fetch
   import vga_pkg::*;
#(
   parameter int unsigned SRC_W     = 320,
   parameter int unsigned SRC_H     = 240,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iRequest,
   input  logic [COORD_W-1:0]    iX,
   input  logic [COORD_W-1:0]    iY,
   input  logic                  iVS,
   output logic                  oRdReq,
   output logic [FB_ADDR_W-1:0]  oRdAddr,
   input  logic                  iRdReady,
   input  logic                  iRdValid,
   input  logic [PIX_W-1:0]      iRdData,
   output logic [COLOR_W-1:0]    oRed,
   output logic [COLOR_W-1:0]    oGreen,
   output logic [COLOR_W-1:0]    oBlue,
   output logic                  oUnderrun
);

   localparam int unsigned IDX_W = $clog2(SRC_W);
   localparam int unsigned CNT_W = IDX_W + 1;

   fetch_state_e          fetchState;
   fetch_state_e          stateNext;

   logic                  vsPrev;
   logic                  reqPrev;
   logic                  trigVs;
   logic                  trigLine;
   logic                  trigAny;
   logic [COORD_W-1:0]    trigLineNum;
   logic [FB_ADDR_W-1:0]  startAddr;

   logic                  fetchBank;
   logic [CNT_W-1:0]      reqCnt;
   logic [CNT_W-1:0]      validCnt;
   logic                  accept;
   logic                  lastReq;
   logic                  validIn;
   logic                  drainDone;
   logic                  rdReqNext;
   logic                  ramWe;
   logic [1:0]            lineReady;

   logic                  rdBank;
   logic [IDX_W-1:0]      rdIdx;
   logic                  pixInRange;
   logic                  pixRead;
   logic                  pixUnderrun;
   logic                  pixOk;
   logic [PIX_W-1:0]      ramQ;
   rgb30_t                pixColor;

   // Trigger detection: falling iVS loads line 0; the first active cycle of an
   // even row prefetches the next source line into the idle bank.
   assign trigVs   = vsPrev && !iVS;
   assign trigLine = iRequest && !reqPrev && (iX == '0) && !iY[0]
                     && ((32'(iY >> 1) + 32'd1) < SRC_H);
   assign trigAny  = trigVs || trigLine;

   assign trigLineNum = trigVs ? '0 : (COORD_W'(iY >> 1) + COORD_W'(1));
   assign startAddr   = FB_ADDR_W'(BASE_ADDR)
                        + FB_ADDR_W'(trigLineNum) * FB_ADDR_W'(SRC_W);

   assign accept    = (fetchState == FETCH_ISSUE) && iRdReady;
   assign lastReq   = (reqCnt == CNT_W'(SRC_W - 1));
   assign validIn   = iRdValid && (fetchState != FETCH_IDLE)
                      && (validCnt < CNT_W'(SRC_W));
   assign drainDone = (validCnt == CNT_W'(SRC_W))
                      || (validIn && (validCnt == CNT_W'(SRC_W - 1)));

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         fetchState <= FETCH_IDLE;
      end else begin
         fetchState <= stateNext;
      end
   end

   always_comb begin
      stateNext = fetchState;
      case (fetchState)
         FETCH_IDLE:  if (trigAny)            stateNext = FETCH_ISSUE;
         FETCH_ISSUE: if (accept && lastReq)  stateNext = FETCH_DRAIN;
         FETCH_DRAIN: if (drainDone)          stateNext = FETCH_IDLE;
         default:                             stateNext = FETCH_IDLE;
      endcase
   end

   always_comb begin
      rdReqNext = 1'b0;
      ramWe     = 1'b0;
      if (stateNext == FETCH_ISSUE) begin
         rdReqNext = 1'b1;
      end
      if (validIn) begin
         ramWe = 1'b1;
      end
   end

   // Fetch bookkeeping: address/counters, bank ready bits and trigger edges.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         vsPrev    <= 1'b0;
         reqPrev   <= 1'b0;
         oRdReq    <= 1'b0;
         oRdAddr   <= '0;
         reqCnt    <= '0;
         validCnt  <= '0;
         fetchBank <= 1'b0;
         lineReady <= '0;
      end else begin
         vsPrev  <= iVS;
         reqPrev <= iRequest;
         oRdReq  <= rdReqNext;
         if ((fetchState == FETCH_IDLE) && trigAny) begin
            oRdAddr                  <= startAddr;
            reqCnt                   <= '0;
            validCnt                 <= '0;
            fetchBank                <= trigLineNum[0];
            lineReady[trigLineNum[0]] <= 1'b0;
         end else begin
            if (accept) begin
               oRdAddr <= oRdAddr + FB_ADDR_W'(1);
               reqCnt  <= reqCnt + CNT_W'(1);
            end
            if (validIn) begin
               validCnt <= validCnt + CNT_W'(1);
            end
            if ((fetchState == FETCH_DRAIN) && drainDone) begin
               lineReady[fetchBank] <= 1'b1;
            end
         end
      end
   end

   vga_line_ram #(
      .DEPTH (SRC_W)
   ) uLineRam (
      .iCLK    (iCLK),
      .iWrEn   (ramWe),
      .iWrBank (fetchBank),
      .iWrIdx  (IDX_W'(validCnt)),
      .iWrData (iRdData),
      .iRdBank (rdBank),
      .iRdIdx  (rdIdx),
      .oRdData (ramQ)
   );

   // Display side: source row iY>>1 lives in bank (iY>>1)[0], i.e. iY[1].
   assign rdBank      = iY[1];
   assign rdIdx       = iX[IDX_W:1];
   assign pixInRange  = (iX < COORD_W'(H_ACTIVE)) && (iY < COORD_W'(V_ACTIVE))
                        && (32'(iX >> 1) < SRC_W) && (32'(iY >> 1) < SRC_H);
   assign pixRead     = iRequest && pixInRange;
   assign pixUnderrun = pixRead && !lineReady[rdBank];

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pixOk     <= 1'b0;
         oUnderrun <= 1'b0;
      end else begin
         pixOk <= pixRead && lineReady[rdBank];
         if (pixUnderrun || (trigAny && (fetchState != FETCH_IDLE))) begin
            oUnderrun <= 1'b1;
         end
      end
   end

   // Colour is the registered RAM word gated by the registered pixel-valid bit.
   assign pixColor = expandRgb565(ramQ);
   assign oRed     = pixOk ? pixColor.red   : '0;
   assign oGreen   = pixOk ? pixColor.green : '0;
   assign oBlue    = pixOk ? pixColor.blue  : '0;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a latency-3 frame-buffer model.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;
   import vga_pkg::*;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iRequest = 1'b0;
   logic [10:0] iX = '0;
   logic [10:0] iY = '0;
   logic        iVS = 1'b1;
   logic        iRdReady = 1'b0;
   logic        iRdValid = 1'b0;
   logic [15:0] iRdData = '0;
   logic        oRdReq;
   logic [16:0] oRdAddr;
   logic [9:0]  oRed, oGreen, oBlue;
   logic        oUnderrun;

   int checks = 0;
   int errors = 0;

   bit          memStall = 0, memJitter = 0, memSolid = 0, memForce = 0;
   bit          pv [3];
   bit [15:0]   pd [3];
   logic [16:0] acceptLog [$];
   int unsigned cyc = 0;

   vga_pixel_fetch dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iRequest(iRequest), .iX(iX), .iY(iY),
      .iVS(iVS), .oRdReq(oRdReq), .oRdAddr(oRdAddr), .iRdReady(iRdReady),
      .iRdValid(iRdValid), .iRdData(iRdData), .oRed(oRed), .oGreen(oGreen),
      .oBlue(oBlue), .oUnderrun(oUnderrun)
   );

   always #5 iCLK = ~iCLK;

   // Memory model: word = address (or solid F800), returned 3 cycles after accept.
   always @(negedge iCLK) begin
      cyc = cyc + 1;
      iRdReady = !memStall && !(memJitter && (cyc % 4 == 3));
      iRdValid = pv[2];
      iRdData  = pd[2];
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = oRdReq && iRdReady;
      pd[0] = memSolid ? 16'hF800 : oRdAddr[15:0];
      if (pv[0]) acceptLog.push_back(oRdAddr);
      if (memForce) begin
         iRdValid = cyc[0];
         iRdData  = 16'hBEEF;
      end
   end

   function automatic logic [29:0] exp565(input logic [15:0] w);
      logic [4:0] r = w[15:11];
      logic [5:0] g = w[10:5];
      logic [4:0] b = w[4:0];
      return {r, r, g, g[5:2], b, b};
   endfunction

   task automatic drivePix(input int x, input int y);
      iRequest = 1'b1;
      iX = 11'(x);
      iY = 11'(y);
      @(negedge iCLK);
   endtask

   task automatic idlePix();
      iRequest = 1'b0;
      @(negedge iCLK);
   endtask

   task automatic waitFetchDone(input string tag);
      int n = 0;
      while (!oRdReq && n < 50) begin @(negedge iCLK); n++; end
      checks++;
      if (oRdReq !== 1'b1) begin
         errors++; $display("FAIL %s_start: oRdReq=%b required 1 within 50 cycles", tag, oRdReq);
      end
      n = 0;
      while (oRdReq && n < 5000) begin @(negedge iCLK); n++; end
      checks++;
      if (oRdReq !== 1'b0) begin
         errors++; $display("FAIL %s_end: oRdReq=%b required 0 within 5000 cycles", tag, oRdReq);
      end
      repeat (8) @(negedge iCLK);
   endtask

   task automatic test_reset();
      iRST_N = 1'b0;
      repeat (3) @(negedge iCLK);
      checks++; if (oRdReq !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b required 0", oRdReq); end
      checks++; if (oRdAddr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", oRdAddr); end
      checks++; if ({oRed, oGreen, oBlue} !== 30'd0) begin errors++; $display("FAIL reset_colour: got %h required 0", {oRed, oGreen, oBlue}); end
      checks++; if (oUnderrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", oUnderrun); end
      iRST_N = 1'b1;
      repeat (3) @(negedge iCLK);
      checks++; if (oRdReq !== 1'b0) begin errors++; $display("FAIL post_reset_rdreq: got %b required 0", oRdReq); end
   endtask

   task automatic test_vsync_fetch();
      acceptLog.delete();
      memJitter = 1;
      iVS = 1'b0; @(negedge iCLK); iVS = 1'b1;
      waitFetchDone("vs_fetch");
      memJitter = 0;
      checks++;
      if (acceptLog.size() != 320) begin errors++; $display("FAIL vs_req_count: got %0d required 320", acceptLog.size()); end
      for (int k = 0; k < acceptLog.size() && k < 320; k++) begin
         checks++;
         if (acceptLog[k] !== 17'(k)) begin errors++; $display("FAIL vs_req_addr[%0d]: got %0d required %0d", k, acceptLog[k], k); end
      end
      drivePix(5, 0);
      checks++; if ({oRed, oGreen, oBlue} !== {10'h000, 10'h000, 10'h042}) begin errors++; $display("FAIL pix_5_0: got %h required %h", {oRed, oGreen, oBlue}, {10'h000, 10'h000, 10'h042}); end
      drivePix(128, 0);
      checks++; if ({oRed, oGreen, oBlue} !== {10'h000, 10'h020, 10'h000}) begin errors++; $display("FAIL pix_128_0: got %h required %h", {oRed, oGreen, oBlue}, {10'h000, 10'h020, 10'h000}); end
      drivePix(512, 0);
      checks++; if ({oRed, oGreen, oBlue} !== {10'h000, 10'h082, 10'h000}) begin errors++; $display("FAIL pix_512_0: got %h required %h", {oRed, oGreen, oBlue}, {10'h000, 10'h082, 10'h000}); end
      idlePix();
      checks++; if ({oRed, oGreen, oBlue} !== 30'd0) begin errors++; $display("FAIL idle_colour: got %h required 0", {oRed, oGreen, oBlue}); end
      drivePix(0, 0);
      checks++; if (oRdReq !== 1'b1 || oRdAddr !== 17'd320) begin errors++; $display("FAIL line1_start: rdreq=%b addr=%0d required 1/320", oRdReq, oRdAddr); end
      checks++; if ({oRed, oGreen, oBlue} !== 30'd0) begin errors++; $display("FAIL pix_0_0: got %h required 0", {oRed, oGreen, oBlue}); end
      idlePix();
      waitFetchDone("line1");
      checks++; if (oUnderrun !== 1'b0) begin errors++; $display("FAIL vs_underrun: got %b required 0", oUnderrun); end
   endtask

   task automatic test_line_fetch();
      int xs [5] = '{0, 2, 7, 255, 639};
      drivePix(0, 18);
      checks++; if (oRdReq !== 1'b1 || oRdAddr !== 17'd3200) begin errors++; $display("FAIL line10_start: rdreq=%b addr=%0d required 1/3200", oRdReq, oRdAddr); end
      checks++; if ({oRed, oGreen, oBlue} !== exp565(16'd320)) begin errors++; $display("FAIL pix_0_18: got %h required %h", {oRed, oGreen, oBlue}, exp565(16'd320)); end
      idlePix();
      waitFetchDone("line10");
      for (int i = 0; i < 5; i++) begin
         drivePix(xs[i], 20);
         if (i == 0) begin
            checks++; if (oRdReq !== 1'b1 || oRdAddr !== 17'd3520) begin errors++; $display("FAIL line11_start: rdreq=%b addr=%0d required 1/3520", oRdReq, oRdAddr); end
            checks++; if ({oRed, oGreen, oBlue} !== {10'h021, 10'h249, 10'h000}) begin errors++; $display("FAIL pix_0_20: got %h required %h", {oRed, oGreen, oBlue}, {10'h021, 10'h249, 10'h000}); end
         end
         checks++; if ({oRed, oGreen, oBlue} !== exp565(16'(3200 + xs[i] / 2))) begin errors++; $display("FAIL row20_x%0d: got %h required %h", xs[i], {oRed, oGreen, oBlue}, exp565(16'(3200 + xs[i] / 2))); end
      end
      idlePix();
      for (int i = 0; i < 5; i++) begin
         drivePix(xs[i], 21);
         checks++; if ({oRed, oGreen, oBlue} !== exp565(16'(3200 + xs[i] / 2))) begin errors++; $display("FAIL row21_x%0d: got %h required %h", xs[i], {oRed, oGreen, oBlue}, exp565(16'(3200 + xs[i] / 2))); end
      end
      idlePix();
      waitFetchDone("line11");
      drivePix(0, 22);
      checks++; if ({oRed, oGreen, oBlue} !== {10'h021, 10'h2EB, 10'h000}) begin errors++; $display("FAIL pix_0_22: got %h required %h", {oRed, oGreen, oBlue}, {10'h021, 10'h2EB, 10'h000}); end
      checks++; if (oRdAddr !== 17'd3840) begin errors++; $display("FAIL line12_start: addr=%0d required 3840", oRdAddr); end
      drivePix(9, 23);
      checks++; if ({oRed, oGreen, oBlue} !== exp565(16'd3524)) begin errors++; $display("FAIL pix_9_23: got %h required %h", {oRed, oGreen, oBlue}, exp565(16'd3524)); end
      idlePix();
      waitFetchDone("line12");
   endtask

   task automatic test_last_line();
      int bad = 0;
      drivePix(0, 476);
      checks++; if (oRdReq !== 1'b1 || oRdAddr !== 17'd76480) begin errors++; $display("FAIL line239_start: rdreq=%b addr=%0d required 1/76480", oRdReq, oRdAddr); end
      checks++; if ({oRed, oGreen, oBlue} !== exp565(16'd3840)) begin errors++; $display("FAIL pix_0_476: got %h required %h", {oRed, oGreen, oBlue}, exp565(16'd3840)); end
      idlePix();
      waitFetchDone("line239");
      drivePix(0, 478);
      checks++; if ({oRed, oGreen, oBlue} !== exp565(16'(76480))) begin errors++; $display("FAIL pix_0_478: got %h required %h", {oRed, oGreen, oBlue}, exp565(16'(76480))); end
      idlePix();
      for (int i = 0; i < 10; i++) begin
         if (oRdReq !== 1'b0) bad++;
         @(negedge iCLK);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL last_line_no_fetch: oRdReq high on %0d cycles required 0", bad); end
      checks++; if (oUnderrun !== 1'b0) begin errors++; $display("FAIL last_line_underrun: got %b required 0", oUnderrun); end
   endtask

   task automatic test_solid();
      memSolid = 1;
      iVS = 1'b0; @(negedge iCLK); iVS = 1'b1;
      waitFetchDone("solid");
      for (int x = 1; x <= 8; x++) begin
         drivePix(x, 0);
         checks++; if ({oRed, oGreen, oBlue} !== {10'h3FF, 10'h000, 10'h000}) begin errors++; $display("FAIL solid_x%0d: got %h required %h", x, {oRed, oGreen, oBlue}, {10'h3FF, 10'h000, 10'h000}); end
      end
      idlePix();
      checks++; if ({oRed, oGreen, oBlue} !== 30'd0) begin errors++; $display("FAIL solid_idle: got %h required 0", {oRed, oGreen, oBlue}); end
      checks++; if (oUnderrun !== 1'b0) begin errors++; $display("FAIL solid_underrun: got %b required 0", oUnderrun); end
      memSolid = 0;
   endtask

   task automatic test_underrun();
      memStall = 1;
      iVS = 1'b0; @(negedge iCLK); iVS = 1'b1;
      repeat (5) @(negedge iCLK);
      checks++; if (oRdReq !== 1'b1) begin errors++; $display("FAIL stall_rdreq: got %b required 1", oRdReq); end
      repeat (2000) @(negedge iCLK);
      checks++; if (oUnderrun !== 1'b0) begin errors++; $display("FAIL stall_pre_underrun: got %b required 0", oUnderrun); end
      drivePix(3, 0);
      checks++; if ({oRed, oGreen, oBlue} !== 30'd0) begin errors++; $display("FAIL stall_pix: got %h required 0", {oRed, oGreen, oBlue}); end
      checks++; if (oUnderrun !== 1'b1) begin errors++; $display("FAIL stall_underrun: got %b required 1", oUnderrun); end
      idlePix();
      drivePix(0, 0);
      checks++; if (oRdAddr !== 17'd0 || oRdReq !== 1'b1) begin errors++; $display("FAIL busy_trigger_dropped: addr=%0d rdreq=%b required 0/1", oRdAddr, oRdReq); end
      idlePix();
      memStall = 0;
      waitFetchDone("stalled");
      drivePix(5, 0);
      checks++; if ({oRed, oGreen, oBlue} !== {10'h000, 10'h000, 10'h042}) begin errors++; $display("FAIL recover_pix: got %h required %h", {oRed, oGreen, oBlue}, {10'h000, 10'h000, 10'h042}); end
      checks++; if (oUnderrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b required 1", oUnderrun); end
      idlePix();
   endtask

   task automatic test_reset_drain();
      int n = 0;
      int bad = 0;
      iVS = 1'b0; @(negedge iCLK); iVS = 1'b1;
      while (!oRdReq && n < 50) begin @(negedge iCLK); n++; end
      n = 0;
      while (oRdReq && n < 2000) begin @(negedge iCLK); n++; end
      checks++; if (oRdReq !== 1'b0) begin errors++; $display("FAIL drain_reach: oRdReq=%b required 0", oRdReq); end
      iRST_N = 1'b0;
      @(negedge iCLK);
      checks++; if (oRdReq !== 1'b0 || oUnderrun !== 1'b0) begin errors++; $display("FAIL drain_reset: rdreq=%b underrun=%b required 0/0", oRdReq, oUnderrun); end
      iRST_N = 1'b1;
      memForce = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge iCLK);
         if (oRdReq !== 1'b0 || dut.ramWe !== 1'b0 || dut.fetchState !== FETCH_IDLE) bad++;
      end
      memForce = 0;
      checks++; if (bad != 0) begin errors++; $display("FAIL late_valid_ignored: %0d bad cycles required 0", bad); end
      checks++; if (oUnderrun !== 1'b0) begin errors++; $display("FAIL drain_underrun: got %b required 0", oUnderrun); end
      checks++; if ({oRed, oGreen, oBlue} !== 30'd0) begin errors++; $display("FAIL drain_colour: got %h required 0", {oRed, oGreen, oBlue}); end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vsync_fetch();
      test_line_fetch();
      test_last_line();
      test_solid();
      test_underrun();
      test_reset_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
